// File: rtl/tracker_pkg.sv
// Shared definitions for the tracker sensor scan path: channel map and scan FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tracker_pkg;

  localparam int N_CH = 6;

  // Analog mux channel map
  localparam logic [2:0] CH_RV1   = 3'd0;
  localparam logic [2:0] CH_RV2   = 3'd1;
  localparam logic [2:0] CH_RH1   = 3'd2;
  localparam logic [2:0] CH_RH2   = 3'd3;
  localparam logic [2:0] CH_THETA = 3'd4;
  localparam logic [2:0] CH_PHI   = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    WAIT,
    NEXT,
    PUBLISH
  } scan_state_t;

endpackage

// File: rtl/sensor_scan_sequencer_sample_averager.sv
// Per-channel sample accumulator: sums 2^AVG_LOG2 ADC samples and presents the truncated mean.
// Latency: avg_dat reflects a sample one cycle after sample_vld.
// Backpressure: none; every sample_vld is accepted, clear wins over a same-cycle sample.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   clear            drop the running sum and sample count
//   sample_vld/_dat  one ADC result to accumulate
//   last             the next accepted sample completes the average
//   avg_dat          accumulated sum >> AVG_LOG2
module sample_averager #(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] sample_dat,
  output logic              last,
  output logic [DATA_W-1:0] avg_dat
);

  // Wide enough that 2^AVG_LOG2 full-scale samples cannot overflow.
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_vld) begin
      acc <= acc + ACC_W'(sample_dat);
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last    = (cnt == LAST_CNT);
  assign avg_dat = acc[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/sensor_scan_sequencer.sv
// Scans six tracker sensors through one ADC (mux, settle, start/done, averaging) and publishes coherent frames.
// Latency: one frame = 6*(SETTLE_CYC + 2^AVG_LOG2*(1+D) + 1) cycles from first SETTLE to the frame_valid cycle.
// Backpressure: none toward the consumer; ADC stalls are bounded by TIMEOUT_CYC, then the frame is aborted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   scan continuously while high, stop at a safe point when low
//   adc_data, adc_done       ADC result and its one-cycle done strobe
//   clr_timeout              clears the sticky timeout flag
//   mux_sel, adc_start       analog mux channel and one-cycle conversion start
//   r_*, theta/phi_actual    averaged channel values, updated together once per frame
//   frame_valid              one-cycle pulse in the cycle the new frame is visible
//   adc_timeout, timeout_ch  sticky timeout flag and the channel that caused it
module sensor_scan_sequencer
  import tracker_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SETTLE_CYC  = 16,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_done,
  input  logic              clr_timeout,
  output logic [2:0]        mux_sel,
  output logic              adc_start,
  output logic [DATA_W-1:0] r_vertical_1,
  output logic [DATA_W-1:0] r_vertical_2,
  output logic [DATA_W-1:0] r_horizontal_1,
  output logic [DATA_W-1:0] r_horizontal_2,
  output logic [DATA_W-1:0] theta_actual,
  output logic [DATA_W-1:0] phi_actual,
  output logic              frame_valid,
  output logic              adc_timeout,
  output logic [2:0]        timeout_ch
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  scan_state_t       state, state_nxt;
  logic [2:0]        ch;
  logic [SET_W-1:0]  settle_cnt;
  logic [TMO_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] shadow [N_CH];

  logic              settle_end;
  logic              done_ok;
  logic              abort;
  logic              last_sample;
  logic              avg_clear;
  logic [DATA_W-1:0] avg_dat;

  assign settle_end = (settle_cnt == SET_W'(SETTLE_CYC - 1));
  // Done strobes are only meaningful in WAIT; stale or early ones fall through.
  assign done_ok    = (state == WAIT) && adc_done;
  assign abort      = (state == WAIT) && !adc_done && (wait_cnt == TMO_W'(TIMEOUT_CYC - 1));
  // Partial sums never survive a channel change, an abort or a stop.
  assign avg_clear  = (state == NEXT) || abort || (state_nxt == IDLE);

  sample_averager #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk        (clk),
    .rst        (rst),
    .clear      (avg_clear),
    .sample_vld (done_ok),
    .sample_dat (adc_data),
    .last       (last_sample),
    .avg_dat    (avg_dat)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; a low enable is honoured only where no conversion is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE:  if (settle_end) state_nxt = enable ? START : IDLE;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (done_ok)    state_nxt = last_sample ? NEXT : (enable ? START : IDLE);
        else if (abort) state_nxt = enable ? SETTLE : IDLE;
      end
      NEXT:    state_nxt = (ch == CH_PHI) ? PUBLISH : (enable ? SETTLE : IDLE);
      PUBLISH: state_nxt = enable ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    adc_start   = (state == START) && !rst;
    frame_valid = (state == PUBLISH) && !rst;
    mux_sel     = ch;
  end

  // Channel index and settle/wait counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ch         <= CH_RV1;
      settle_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if (state_nxt == IDLE) begin
        ch <= CH_RV1;
      end else if (state != SETTLE && state_nxt == SETTLE) begin
        // Only NEXT advances the channel; every other entry into SETTLE starts a fresh frame.
        ch <= (state == NEXT) ? ch + 3'd1 : CH_RV1;
      end
      settle_cnt <= (state == SETTLE) ? settle_cnt + SET_W'(1) : '0;
      wait_cnt   <= (state == WAIT)   ? wait_cnt + TMO_W'(1)   : '0;
    end
  end

  // Shadow bank
  always_ff @(posedge clk) begin
    if (rst || abort || state_nxt == IDLE) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
    end else if (state == NEXT) begin
      shadow[ch] <= avg_dat;
    end
  end

  // Output bank loads on the NEXT(phi) -> PUBLISH edge so the new values and
  // frame_valid appear in the same cycle; phi bypasses its shadow slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vertical_1   <= '0;
      r_vertical_2   <= '0;
      r_horizontal_1 <= '0;
      r_horizontal_2 <= '0;
      theta_actual   <= '0;
      phi_actual     <= '0;
    end else if (state == NEXT && ch == CH_PHI) begin
      r_vertical_1   <= shadow[CH_RV1];
      r_vertical_2   <= shadow[CH_RV2];
      r_horizontal_1 <= shadow[CH_RH1];
      r_horizontal_2 <= shadow[CH_RH2];
      theta_actual   <= shadow[CH_THETA];
      phi_actual     <= avg_dat;
    end
  end

  // Sticky timeout flag; a new timeout beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_timeout <= 1'b0;
      timeout_ch  <= '0;
    end else if (abort) begin
      adc_timeout <= 1'b1;
      timeout_ch  <= ch;
    end else if (clr_timeout) begin
      adc_timeout <= 1'b0;
      timeout_ch  <= '0;
    end
  end

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// Directed-plus-random bench for sensor_scan_sequencer with an ADC model and frame scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sensor_scan_sequencer;

  localparam int DATA_W      = 16;
  localparam int SETTLE_CYC  = 16;
  localparam int AVG_LOG2    = 2;
  localparam int TIMEOUT_CYC = 1024;
  localparam int N_AVG       = 1 << AVG_LOG2;
  localparam int FIX_D       = 3;
  localparam int CH_TIME     = SETTLE_CYC + N_AVG * (1 + FIX_D) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_done = 1'b0;
  logic              clr_timeout = 1'b0;
  logic [2:0]        mux_sel;
  logic              adc_start;
  logic [DATA_W-1:0] r_vertical_1, r_vertical_2, r_horizontal_1, r_horizontal_2;
  logic [DATA_W-1:0] theta_actual, phi_actual;
  logic              frame_valid;
  logic              adc_timeout;
  logic [2:0]        timeout_ch;

  always #5 clk = ~clk;

  sensor_scan_sequencer #(
    .DATA_W      (DATA_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .AVG_LOG2    (AVG_LOG2),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .adc_data       (adc_data),
    .adc_done       (adc_done),
    .clr_timeout    (clr_timeout),
    .mux_sel        (mux_sel),
    .adc_start      (adc_start),
    .r_vertical_1   (r_vertical_1),
    .r_vertical_2   (r_vertical_2),
    .r_horizontal_1 (r_horizontal_1),
    .r_horizontal_2 (r_horizontal_2),
    .theta_actual   (theta_actual),
    .phi_actual     (phi_actual),
    .frame_valid    (frame_valid),
    .adc_timeout    (adc_timeout),
    .timeout_ch     (timeout_ch)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: per-frame sample sums and start counts per channel
  int          sum [6];
  int          starts [6];
  int          pend = 0;
  int          pend_ch = 0;
  logic [15:0] pend_dat = '0;
  bit          stale = 1'b0;
  int          data_mode = 0;
  bit          inject = 1'b0;
  bit          fix_d = 1'b1;
  int          dead_ch = -1;
  int          nstarts = 0;
  int          nframes = 0;
  int          dead_start_cyc = 0;
  int          fv_cyc = 0;
  bit          fv_now = 1'b0;
  logic [15:0] ch0_tbl [4] = '{16'd10, 16'd11, 16'd12, 16'd14};
  logic [15:0] saved [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] out_of(input int c);
    case (c)
      0:       return r_vertical_1;
      1:       return r_vertical_2;
      2:       return r_horizontal_1;
      3:       return r_horizontal_2;
      4:       return theta_actual;
      default: return phi_actual;
    endcase
  endfunction

  function automatic logic [15:0] gen(input int c, input int idx);
    case (data_mode)
      0:       return 16'(100 * (c + 1));
      1:       return (c == 0 && idx < 4) ? ch0_tbl[idx] : 16'($urandom);
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 6; c++) begin
      sum[c]    = 0;
      starts[c] = 0;
    end
  endtask

  // One clock cycle: sample DUT at the falling edge, score frames, drive the ADC.
  task automatic step();
    @(negedge clk);
    cyc++;
    fv_now   = 1'b0;
    adc_done = 1'b0;
    adc_data = '0;
    if (rst) begin
      model_clear();
      stale = 1'b1;
    end
    if (frame_valid) begin
      fv_now = 1'b1;
      fv_cyc = cyc;
      nframes++;
      for (int c = 0; c < 6; c++) begin
        check($sformatf("frame_avg_ch%0d", c), 32'(out_of(c)), 32'(sum[c] / N_AVG));
        check($sformatf("frame_samples_ch%0d", c), 32'(starts[c]), 32'(N_AVG));
      end
      model_clear();
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        adc_done = 1'b1;
        adc_data = pend_dat;
        if (!stale) sum[pend_ch] += int'(pend_dat);
      end
    end else if (inject && !adc_start && $urandom_range(0, 2) == 0) begin
      adc_done = 1'b1;
      adc_data = 16'($urandom);
    end
    if (adc_start) begin
      nstarts++;
      stale = 1'b0;
      if (int'(mux_sel) == dead_ch) begin
        model_clear();
        dead_start_cyc = cyc;
      end else begin
        pend_ch  = int'(mux_sel);
        pend_dat = gen(pend_ch, starts[pend_ch]);
        pend     = fix_d ? FIX_D : int'($urandom_range(1, 5));
        starts[pend_ch]++;
      end
      if (inject) begin
        adc_done = 1'b1;
        adc_data = 16'($urandom);
      end
    end
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = fv_now;
    end
  endtask

  task automatic wait_start_on(input logic [2:0] c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = adc_start && (mux_sel == c);
    end
  endtask

  initial begin
    bit   ok;
    int   e, n0, fr0;
    logic nonzero;

    model_clear();

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    for (int c = 0; c < 6; c++) check($sformatf("reset_out_ch%0d", c), 32'(out_of(c)), 32'd0);
    check("reset_mux_sel", 32'(mux_sel), 32'd0);
    check("reset_adc_start", 32'(adc_start), 32'd0);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    check("reset_adc_timeout", 32'(adc_timeout), 32'd0);
    check("reset_timeout_ch", 32'(timeout_ch), 32'd0);

    // Constant per-channel data, D=3: frame timing, values and start count
    data_mode = 0;
    fix_d     = 1'b1;
    enable    = 1'b1;
    e         = cyc;
    wait_frame(400, ok);
    enable = 1'b0;
    check("const_frame_seen", 32'(ok), 32'd1);
    check("const_frame_latency", 32'(fv_cyc - e), 32'(6 * CH_TIME + 1));
    for (int c = 0; c < 6; c++) check($sformatf("const_out_ch%0d", c), 32'(out_of(c)), 32'(100 * (c + 1)));
    check("const_start_pulses", 32'(nstarts), 32'd24);
    repeat (3) step();

    // Truncating average, then full-scale inputs
    data_mode = 1;
    enable    = 1'b1;
    wait_frame(400, ok);
    check("trunc_frame_seen", 32'(ok), 32'd1);
    check("trunc_rv1", 32'(r_vertical_1), 32'd11);
    data_mode = 2;
    wait_frame(400, ok);
    enable = 1'b0;
    check("fullscale_frame_seen", 32'(ok), 32'd1);
    for (int c = 0; c < 6; c++) check($sformatf("fullscale_ch%0d", c), 32'(out_of(c)), 32'hFFFF);
    for (int c = 0; c < 6; c++) saved[c] = out_of(c);
    repeat (3) step();

    // ADC never answers on channel 3
    data_mode = 3;
    fix_d     = 1'b0;
    dead_ch   = 3;
    fr0       = nframes;
    enable    = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      ok = adc_timeout;
    end
    dead_ch = -1;
    check("timeout_seen", 32'(ok), 32'd1);
    check("timeout_latency", 32'(cyc - dead_start_cyc), 32'(TIMEOUT_CYC + 1));
    check("timeout_ch", 32'(timeout_ch), 32'd3);
    check("timeout_restart_mux", 32'(mux_sel), 32'd0);
    check("timeout_no_frame", 32'(nframes), 32'(fr0));
    for (int c = 0; c < 6; c++) check($sformatf("timeout_hold_ch%0d", c), 32'(out_of(c)), 32'(saved[c]));
    wait_frame(1000, ok);
    enable = 1'b0;
    check("post_timeout_frame_seen", 32'(ok), 32'd1);
    check("timeout_sticky", 32'(adc_timeout), 32'd1);
    repeat (2) step();
    clr_timeout = 1'b1;
    step();
    clr_timeout = 1'b0;
    check("clr_timeout_flag", 32'(adc_timeout), 32'd0);
    check("clr_timeout_ch", 32'(timeout_ch), 32'd0);
    for (int c = 0; c < 6; c++) saved[c] = out_of(c);

    // Drop enable during a channel-2 conversion
    data_mode = 0;
    fix_d     = 1'b1;
    enable    = 1'b1;
    wait_start_on(3'd2, 500, ok);
    check("drop_reached_ch2", 32'(ok), 32'd1);
    step();
    enable = 1'b0;
    n0     = nstarts;
    fr0    = nframes;
    repeat (40) step();
    check("drop_no_more_starts", 32'(nstarts), 32'(n0));
    check("drop_no_frame", 32'(nframes), 32'(fr0));
    check("drop_idle_mux", 32'(mux_sel), 32'd0);
    for (int c = 0; c < 6; c++) check($sformatf("drop_hold_ch%0d", c), 32'(out_of(c)), 32'(saved[c]));
    model_clear();

    // Spurious dones in SETTLE and START, random data and latency, back-to-back frames
    data_mode = 3;
    fix_d     = 1'b0;
    inject    = 1'b1;
    enable    = 1'b1;
    wait_frame(1500, ok);
    inject = 1'b0;
    check("inject_frame_seen", 32'(ok), 32'd1);
    wait_frame(1500, ok);
    enable = 1'b0;
    check("random_frame_seen", 32'(ok), 32'd1);
    repeat (3) step();

    // Reset during WAIT with a late done afterwards
    fix_d  = 1'b1;
    enable = 1'b1;
    wait_start_on(3'd1, 500, ok);
    check("rst_reached_ch1", 32'(ok), 32'd1);
    step();
    rst = 1'b1;
    step();
    for (int c = 0; c < 6; c++) check($sformatf("rst_out_ch%0d", c), 32'(out_of(c)), 32'd0);
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_adc_start", 32'(adc_start), 32'd0);
    rst     = 1'b0;
    nonzero = 1'b0;
    ok      = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      ok = fv_now;
      if (!ok) for (int c = 0; c < 6; c++) nonzero = nonzero | (|out_of(c));
    end
    enable = 1'b0;
    check("rst_frame_seen", 32'(ok), 32'd1);
    check("rst_outputs_zero_until_frame", 32'(nonzero), 32'd0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
